// File: rtl/snake_body.sv
// Snake body owner: head/segment list, heading, growth and wall/self collision.
// Steps one cell per enable pulse while running; drives the body occupancy grid.
module snake_body #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned START_X  = 8,
  parameter int unsigned START_Y  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [1:0]        dir_req,
  input  logic              dir_valid,
  input  logic              apple_eaten,
  output logic [3:0]        head_x,
  output logic [3:0]        head_y,
  output logic [4:0]        length,
  output logic              collision,
  output logic [15:0][15:0] body_grid
);

  localparam int unsigned LEN_W = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t     state, state_nx;
  dir_t       heading, heading_mv, heading_ref;
  logic       grow_pending;
  logic [3:0] seg_x [MAX_LEN];
  logic [3:0] seg_y [MAX_LEN];

  logic       run;
  logic       do_move, do_init;
  logic       wall_hit, self_hit;
  logic [3:0] next_x, next_y;
  logic       grow_now;
  logic [LEN_W-1:0] hit_limit;

  function automatic logic [3:0] init_x(input int unsigned i);
    return (i < INIT_LEN) ? 4'(START_X - i) : 4'd0;
  endfunction

  function automatic logic [3:0] init_y(input int unsigned i);
    return (i < INIT_LEN) ? 4'(START_Y) : 4'd0;
  endfunction

  assign run      = (state == ST_RUN);
  assign head_x   = seg_x[0];
  assign head_y   = seg_y[0];
  assign grow_now = grow_pending && (length < LEN_W'(MAX_LEN));

  // Candidate next head cell and wall detection (no wrap-around)
  always_comb begin
    next_x   = seg_x[0];
    next_y   = seg_y[0];
    wall_hit = 1'b0;
    unique case (heading)
      DIR_UP:    begin wall_hit = (seg_y[0] == 4'd0);  next_y = seg_y[0] - 4'd1; end
      DIR_DOWN:  begin wall_hit = (seg_y[0] == 4'd15); next_y = seg_y[0] + 4'd1; end
      DIR_LEFT:  begin wall_hit = (seg_x[0] == 4'd0);  next_x = seg_x[0] - 4'd1; end
      default:   begin wall_hit = (seg_x[0] == 4'd15); next_x = seg_x[0] + 4'd1; end
    endcase
  end

  // Tail cell vacates on a plain move, so it only counts when the move grows
  always_comb begin
    hit_limit = grow_now ? length : length - LEN_W'(1);
    self_hit  = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LEN_W'(i) < hit_limit) && (seg_x[i] == next_x) && (seg_y[i] == next_y))
        self_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_move  = 1'b0;
    do_init  = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        if (enable) begin
          if (wall_hit || self_hit) state_nx = ST_DEAD;
          else                      do_move  = 1'b1;
        end
      end
      ST_DEAD: begin
        if (start) begin
          state_nx = ST_RUN;
          do_init  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Reversal is judged against the heading of the last committed move
  assign heading_ref = do_move ? heading : heading_mv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= init_y(i);
      end
      length       <= LEN_W'(INIT_LEN);
      heading      <= DIR_RIGHT;
      heading_mv   <= DIR_RIGHT;
      grow_pending <= 1'b0;
      collision    <= 1'b0;
    end else begin
      collision <= (state_nx == ST_DEAD);
      if (do_init) begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
          seg_x[i] <= init_x(i);
          seg_y[i] <= init_y(i);
        end
        length       <= LEN_W'(INIT_LEN);
        heading      <= DIR_RIGHT;
        heading_mv   <= DIR_RIGHT;
        grow_pending <= 1'b0;
      end else begin
        if (do_move) begin
          for (int i = 1; i < int'(MAX_LEN); i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0]   <= next_x;
          seg_y[0]   <= next_y;
          heading_mv <= heading;
          if (grow_now) length <= length + LEN_W'(1);
        end
        if (run && dir_valid && (dir_req != (2'(heading_ref) ^ 2'b01)))
          heading <= dir_t'(dir_req);
        if (run) begin
          if (apple_eaten)  grow_pending <= 1'b1;
          else if (do_move) grow_pending <= 1'b0;
        end
      end
    end
  end

  // Occupancy grid decoded straight from the live segments
  always_comb begin
    body_grid = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (LEN_W'(i) < length) body_grid[seg_y[i]][seg_x[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: movement, turning, growth, wall/self hits, reset.
module tb_snake_body;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable, start, dir_valid, apple_eaten;
  logic [1:0]        dir_req;
  logic [3:0]        head_x, head_y;
  logic [4:0]        length;
  logic              collision;
  logic [15:0][15:0] body_grid;
  logic [15:0][15:0] exp_grid;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  snake_body dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start),
    .dir_req(dir_req), .dir_valid(dir_valid), .apple_eaten(apple_eaten),
    .head_x(head_x), .head_y(head_y), .length(length),
    .collision(collision), .body_grid(body_grid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    enable = 1'b1; cyc(); enable = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic apple();
    apple_eaten = 1'b1; cyc(); apple_eaten = 1'b0;
  endtask

  task automatic turn(input logic [1:0] d);
    dir_req = d; dir_valid = 1'b1; cyc(); dir_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int x, input int y, input int len, input int col);
    chk({tag, ".x"},   32'(head_x),    32'(x));
    chk({tag, ".y"},   32'(head_y),    32'(y));
    chk({tag, ".len"}, 32'(length),    32'(len));
    chk({tag, ".col"}, 32'(collision), 32'(col));
  endtask

  task automatic grid_clear();
    exp_grid = '0;
  endtask

  task automatic grid_set(input int x, input int y);
    exp_grid[y][x] = 1'b1;
  endtask

  task automatic chk_grid(input string tag);
    checks++;
    assert (body_grid === exp_grid) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, body_grid, exp_grid);
    end
  endtask

  task automatic grid_init();
    grid_clear(); grid_set(8, 8); grid_set(7, 8); grid_set(6, 8);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; start = 1'b0; dir_valid = 1'b0;
    apple_eaten = 1'b0; dir_req = 2'd0; exp_grid = '0;
    #12;
    chk_state("reset", 8, 8, 3, 0);
    grid_init(); chk_grid("reset.grid");
    rst = 1'b1;
    cyc();

    // IDLE ignores ticks
    tick();
    chk_state("idle_tick", 8, 8, 3, 0);

    // 1: start and four moves right
    do_start();
    chk_state("start_no_move", 8, 8, 3, 0);
    for (int i = 0; i < 4; i++) tick();
    chk_state("run4", 12, 8, 3, 0);
    grid_clear(); grid_set(10, 8); grid_set(11, 8); grid_set(12, 8);
    chk_grid("run4.grid");

    // 2: reversal rejected, then legal turn up
    turn(LEFT); tick();
    chk_state("reverse_rejected", 13, 8, 3, 0);
    turn(UP); tick();
    chk_state("turn_up", 13, 7, 3, 0);

    // 3: growth keeps tail, then plain move drops it
    apple(); tick();
    chk_state("grow", 13, 6, 4, 0);
    grid_clear(); grid_set(13, 6); grid_set(13, 7); grid_set(13, 8); grid_set(12, 8);
    chk_grid("grow.grid");
    tick();
    chk_state("after_grow", 13, 5, 4, 0);
    grid_clear(); grid_set(13, 5); grid_set(13, 6); grid_set(13, 7); grid_set(13, 8);
    chk_grid("after_grow.grid");

    // 4: right wall at x=15
    turn(RIGHT); tick(); tick();
    chk_state("at_wall", 15, 5, 4, 0);
    tick();
    chk_state("wall_hit", 15, 5, 4, 1);
    tick(); apple(); turn(DOWN);
    chk_state("dead_hold", 15, 5, 4, 1);
    do_start();
    chk_state("restart", 8, 8, 3, 0);
    grid_init(); chk_grid("restart.grid");
    tick();
    chk_state("restart_run", 9, 8, 3, 0);

    // 5a: length-5 loop runs into its own body
    apple(); tick(); apple(); tick();
    chk_state("len5", 11, 8, 5, 0);
    turn(UP); tick(); turn(LEFT); tick(); turn(DOWN); tick();
    chk_state("self_hit", 10, 7, 5, 1);

    // 5b: length-4 loop chases its vacating tail
    do_start();
    apple(); tick();
    chk_state("len4", 9, 8, 4, 0);
    turn(UP); tick(); turn(LEFT); tick(); turn(DOWN); tick();
    chk_state("tail_chase", 8, 8, 4, 0);

    // 6: grow to MAX_LEN then saturate
    for (int i = 0; i < 7; i++) begin apple(); tick(); end
    chk_state("len11", 8, 15, 11, 0);
    turn(LEFT);
    for (int i = 0; i < 5; i++) begin apple(); tick(); end
    chk_state("len16", 3, 15, 16, 0);
    apple(); tick();
    chk_state("len16_sat", 2, 15, 16, 0);
    grid_clear();
    for (int x = 2; x <= 8; x++) grid_set(x, 15);
    for (int y = 7; y <= 14; y++) grid_set(8, y);
    grid_set(9, 7);
    chk_grid("len16.grid");
    tick();
    chk_state("len16_hold", 1, 15, 16, 0);

    // Async reset in the middle of a move
    enable = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_state("async_rst", 8, 8, 3, 0);
    grid_init(); chk_grid("async_rst.grid");
    enable = 1'b0;
    cyc();
    rst = 1'b1;
    tick();
    chk_state("post_rst_idle", 8, 8, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
